// File: rtl/sum_level_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sum_level_monitor
// Purpose  : Watches the 11-bit running sum of the last four 8-bit samples.
//            Produces a registered average, and a debounced high-level alarm
//            with hysteresis (arm at >= HI_TH, clear at <= LO_TH), each
//            transition requiring HOLD consecutive qualifying samples.
//            Reports rise/fall pulses, a saturating alarm-event count and an
//            optional running peak of the sum.
// Ports    : clk        - clock, all state updates on rising edge
//            reset      - synchronous, active-high reset
//            sum[10:0]  - window sum, sampled every rising edge
//            avg[7:0]   - registered min(sum >> 2, 255)
//            alarm      - registered alarm level
//            rise       - one-cycle pulse when alarm goes 0->1
//            fall       - one-cycle pulse when alarm goes 1->0
//            event_cnt  - alarm assertions since reset, saturates at 255
//            peak[10:0] - max sum since reset (0 when peak tracking is off)
// Config   : LEVEL_MON_PEAK_EN - define to build the peak register.
// Revision : 1.0 - initial release
// ============================================================================
module sum_level_monitor #(
  parameter int HI_TH = 800,
  parameter int LO_TH = 400,
  parameter int HOLD  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] sum,
  output logic [7:0]  avg,
  output logic        alarm,
  output logic        rise,
  output logic        fall,
  output logic [7:0]  event_cnt,
  output logic [10:0] peak
);

  localparam logic [10:0] C_HI_TH     = HI_TH[10:0];
  localparam logic [10:0] C_LO_TH     = LO_TH[10:0];
  localparam logic [3:0]  C_HOLD_LAST = 4'(HOLD - 1);
  localparam logic        C_HOLD_ONE  = (HOLD == 1);
  localparam logic [7:0]  C_CNT_MAX   = 8'd255;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMING   = 2'd1,
    S_ALARM    = 2'd2,
    S_CLEARING = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  avg_q, avg_d;
  logic        alarm_q, alarm_d;
  logic        rise_q, rise_d;
  logic        fall_q, fall_d;
  logic [7:0]  event_cnt_q, event_cnt_d;

  logic w_hi;
  logic w_lo;

  assign w_hi = (sum >= C_HI_TH);
  assign w_lo = (sum <= C_LO_TH);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    event_cnt_d = event_cnt_q;
    alarm_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_hi) begin
          if (C_HOLD_ONE) begin
            state_d = S_ALARM;
            cnt_d   = 4'd0;
            rise_d  = 1'b1;
          end else begin
            state_d = S_ARMING;
            cnt_d   = 4'd1;
          end
        end
      end
      S_ARMING: begin
        if (w_hi) begin
          if (cnt_q == C_HOLD_LAST) begin
            state_d = S_ALARM;
            cnt_d   = 4'd0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end
      S_ALARM: begin
        if (w_lo) begin
          if (C_HOLD_ONE) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            fall_d  = 1'b1;
          end else begin
            state_d = S_CLEARING;
            cnt_d   = 4'd1;
          end
        end
      end
      S_CLEARING: begin
        if (w_lo) begin
          if (cnt_q == C_HOLD_LAST) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          // Bounce back above LO_TH: alarm never dropped, so no pulse.
          state_d = S_ALARM;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    alarm_d = (state_d == S_ALARM) || (state_d == S_CLEARING);

    if (rise_d && (event_cnt_q != C_CNT_MAX)) begin
      event_cnt_d = event_cnt_q + 8'd1;
    end
  end

  // sum[10:2] is 9 bits; its MSB is sum[10], which forces saturation.
  assign avg_d = sum[10] ? 8'hFF : sum[9:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      avg_q       <= 8'd0;
      alarm_q     <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      event_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      alarm_q     <= alarm_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      event_cnt_q <= event_cnt_d;
    end
  end

  assign avg       = avg_q;
  assign alarm     = alarm_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign event_cnt = event_cnt_q;

`ifdef LEVEL_MON_PEAK_EN
  logic [10:0] peak_q, peak_d;

  assign peak_d = (sum > peak_q) ? sum : peak_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q <= 11'd0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`else
  assign peak = 11'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sum_level_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_level_monitor
// Purpose  : Scoreboard bench for sum_level_monitor. Two instances share one
//            sum stream: default thresholds with HOLD=3, and HOLD=1. A
//            run-length reference model predicts every output per edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_level_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] sum = 11'd0;

  logic [7:0]  a_avg, b_avg;
  logic        a_alarm, b_alarm;
  logic        a_rise, b_rise;
  logic        a_fall, b_fall;
  logic [7:0]  a_ev, b_ev;
  logic [10:0] a_peak, b_peak;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sum_level_monitor #(.HI_TH(800), .LO_TH(400), .HOLD(3)) u_dut_h3 (
    .clk(clk), .reset(reset), .sum(sum),
    .avg(a_avg), .alarm(a_alarm), .rise(a_rise), .fall(a_fall),
    .event_cnt(a_ev), .peak(a_peak)
  );

  sum_level_monitor #(.HI_TH(800), .LO_TH(400), .HOLD(1)) u_dut_h1 (
    .clk(clk), .reset(reset), .sum(sum),
    .avg(b_avg), .alarm(b_alarm), .rise(b_rise), .fall(b_fall),
    .event_cnt(b_ev), .peak(b_peak)
  );

  typedef struct packed {
    logic [7:0]  avg;
    logic        alarm;
    logic        rise;
    logic        fall;
    logic [7:0]  ev;
    logic [10:0] peak;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state, index 0 = HOLD 3, index 1 = HOLD 1
  int m_alarm[2];
  int m_run[2];
  int m_ev[2];
  int m_peak[2];
  int m_hold[2] = '{3, 1};

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts consecutive qualifying samples in the current alarm level and
  // flips the level once the run reaches HOLD.
  task automatic model(input int k, input int s, input bit r, output exp_t e);
    int a;
    e = '0;
    if (r) begin
      m_alarm[k] = 0;
      m_run[k]   = 0;
      m_ev[k]    = 0;
      m_peak[k]  = 0;
    end else begin
      if (m_alarm[k] == 0) begin
        m_run[k] = (s >= 800) ? m_run[k] + 1 : 0;
        if (m_run[k] >= m_hold[k]) begin
          m_alarm[k] = 1;
          m_run[k]   = 0;
          e.rise     = 1'b1;
          if (m_ev[k] < 255) m_ev[k]++;
        end
      end else begin
        m_run[k] = (s <= 400) ? m_run[k] + 1 : 0;
        if (m_run[k] >= m_hold[k]) begin
          m_alarm[k] = 0;
          m_run[k]   = 0;
          e.fall     = 1'b1;
        end
      end
      if (s > m_peak[k]) m_peak[k] = s;
      a = s / 4;
      e.avg = (a > 255) ? 8'd255 : 8'(a);
    end
    e.alarm = (m_alarm[k] != 0);
    e.ev    = 8'(m_ev[k]);
`ifdef LEVEL_MON_PEAK_EN
    e.peak  = 11'(m_peak[k]);
`else
    e.peak  = 11'd0;
`endif
  endtask

  task automatic compare(input string who, input exp_t e,
                         input logic [7:0] avg, input logic alarm,
                         input logic rise, input logic fall,
                         input logic [7:0] ev, input logic [10:0] peak);
    check({who, ".avg"},   int'(avg),   int'(e.avg));
    check({who, ".alarm"}, int'(alarm), int'(e.alarm));
    check({who, ".rise"},  int'(rise),  int'(e.rise));
    check({who, ".fall"},  int'(fall),  int'(e.fall));
    check({who, ".ev"},    int'(ev),    int'(e.ev));
    check({who, ".peak"},  int'(peak),  int'(e.peak));
  endtask

  // Drive one sample, push predictions, then compare #1 after the edge.
  task automatic step(input int s, input bit r);
    exp_t e;
    sum   = 11'(s);
    reset = r;
    model(0, s, r, e);
    q0.push_back(e);
    model(1, s, r, e);
    q1.push_back(e);
    @(posedge clk);
    #1;
    if (q0.size() == 0 || q1.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: queue empty");
    end else begin
      compare("h3", q0.pop_front(), a_avg, a_alarm, a_rise, a_fall, a_ev, a_peak);
      compare("h1", q1.pop_front(), b_avg, b_alarm, b_rise, b_fall, b_ev, b_peak);
    end
  endtask

  initial begin
    // Reset with a large sum present
    step(1020, 1'b1);
    // Assert after three high samples
    repeat (3) step(1020, 1'b0);
    // Clear
    repeat (3) step(400, 1'b0);
    // Interrupted arming restarts the hold count
    step(1020, 1'b0);
    step(1020, 1'b0);
    step(300, 1'b0);
    step(1020, 1'b0);
    step(1020, 1'b0);
    step(1020, 1'b0);
    // Hysteresis band keeps the alarm
    repeat (10) step(600, 1'b0);
    // Partial clear then bounce back
    step(400, 1'b0);
    step(400, 1'b0);
    step(500, 1'b0);
    repeat (3) step(400, 1'b0);
    // Thresholds exactly at the boundary and just off it
    step(799, 1'b0);
    repeat (3) step(800, 1'b0);
    step(401, 1'b0);
    // Reset in the middle of an active alarm
    step(0, 1'b1);
    repeat (2) step(0, 1'b0);
    repeat (3) step(1020, 1'b0);
    // Full-scale sum
    step(2047, 1'b0);
    repeat (3) step(0, 1'b0);
    // Drive the HOLD=1 event counter into saturation
    for (int i = 0; i < 260; i++) begin
      step(1020, 1'b0);
      step(0, 1'b0);
    end
    check("h1.ev_saturated", int'(b_ev), 255);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sum_level_monitor.md
# sum_level_monitor

Downstream consumer of the 4-sample window sum (11-bit running sum of the last four 8-bit samples). Samples the window sum every clock and produces a registered average. Detects sustained high-level conditions with threshold hysteresis and a hold (debounce) counter. Reports alarm state, rise/fall pulses, an alarm-event count and an optional peak.

## Interface
- HI_TH, 800: alarm-arm threshold; a sample qualifies high when sum >= HI_TH (11-bit)
- LO_TH, 400: alarm-clear threshold; a sample qualifies low when sum <= LO_TH; LO_TH < HI_TH required
- HOLD, 3: consecutive qualifying samples needed to change alarm state; legal 1..15

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- sum  input  11  window sum from upstream stage, sampled every rising edge
- avg  output  8  registered min(sum >> 2, 255)
- alarm  output  1  registered alarm level
- rise  output  1  one-cycle pulse on the edge alarm goes 0->1
- fall  output  1  one-cycle pulse on the edge alarm goes 1->0
- event_cnt  output  8  number of alarm assertions since reset, saturates at 255
- peak  output  11  maximum sum sampled since reset (see Configuration)

## Operation
- Reset (reset=1 at an edge): state IDLE, hold counter 0, avg=0, alarm=0, rise=0, fall=0, event_cnt=0, peak=0. Reset overrides every other action, including mid-ARMING/CLEARING.
- States: IDLE, ARMING, ALARM, CLEARING. Hold counter cnt is 4 bits.
- IDLE: if sum >= HI_TH, go to ARMING with cnt=1. If HOLD==1, go to ALARM directly. Otherwise stay.
- ARMING: if sum >= HI_TH and cnt==HOLD-1, go to ALARM. If sum >= HI_TH with cnt below that, cnt++. If sum < HI_TH, go to IDLE with cnt=0; a later qualifying sample restarts from 1.
- ALARM: if sum <= LO_TH, go to CLEARING with cnt=1. If HOLD==1, go to IDLE directly. Otherwise stay. Samples between LO_TH and HI_TH keep the alarm.
- CLEARING: if sum <= LO_TH and cnt==HOLD-1, go to IDLE. If sum <= LO_TH with cnt below that, cnt++. If sum > LO_TH, return to ALARM with cnt=0.
- alarm=1 exactly while the state is ALARM or CLEARING.
- Entering ALARM from IDLE/ARMING: rise=1 for that cycle and event_cnt increments, unless it is already 255.
- Entering IDLE from ALARM/CLEARING: fall=1 for that cycle.
- Returning from CLEARING to ALARM produces no pulse and no count.
- rise and fall are never both 1.
- avg: sum[10:2]; if bit 8 of that value is set, output 255.
- Arithmetic is unsigned; threshold compares use the full 11 bits.

## Timing
- All outputs are registered and update on the same edge that samples sum.
- avg latency: 1 edge.
- Alarm assertion: sum >= HI_TH on HOLD consecutive edges. alarm, rise and event_cnt update on the HOLD-th edge.
- Deassertion: sum <= LO_TH on HOLD consecutive edges. alarm=0 and fall=1 on the HOLD-th edge.
- No handshake: sum is valid every cycle; no backpressure.

## Configuration
- LEVEL_MON_PEAK_EN defined: on each non-reset edge, peak <= max(peak, sum). Cleared by reset.
- LEVEL_MON_PEAK_EN not defined: no peak register; peak is tied to 11'd0.

## Test plan
- Reset with sum=1020 -> next edge: avg=0, alarm=0, rise=0, fall=0, event_cnt=0, peak=0.
- Defaults, sum=1020 held for 3 edges -> alarm=1 and rise=1 on edge 3 only; event_cnt=1; avg=255; peak=1020 (PEAK_EN).
- sum 1020, 1020, 300, 1020, 1020 -> no alarm (counter restarted); a sixth sample of 1020 asserts alarm.
- Alarm active, sum=600 for 10 edges -> alarm stays 1. Then 400, 400, 500 -> back to ALARM, no fall. Then 400 x3 -> fall=1 and alarm=0 on the third.
- Alarm active, reset pulsed for one edge, then sum=0 -> all outputs 0; event_cnt restarts from 0 on the next alarm.
- sum=2047 -> avg=255, peak=2047. After 256 alarm assertion/clear cycles with HOLD=1 -> event_cnt=255 (saturated).
